// File: rtl/pb_event_arbiter.sv
// Pushbutton front end: synchronizes and debounces N buttons on a shared sample
// tick, turns presses into pending requests and serializes them round-robin.
module pb_event_arbiter #(
    parameter int N_BTN          = 4,
    parameter int CLK_FREQ       = 50_000_000,
    parameter int SAMPLE_HZ      = 1_000,
    parameter int STABLE_SAMPLES = 3,
    parameter int IDW            = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] pb_in,
    input  logic             ev_ready,
    output logic             ev_valid,
    output logic [IDW-1:0]   ev_id,
    output logic [N_BTN-1:0] pb_level,
    output logic [N_BTN-1:0] ev_drop
);

    localparam int TICK_DIV = CLK_FREQ / SAMPLE_HZ;
    localparam int CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_OFFER = 1'b1;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic             tick;
    logic [N_BTN-1:0] sync1_q, sync1_d;
    logic [N_BTN-1:0] sync2_q, sync2_d;
    logic [N_BTN-1:0] level_q, level_d;
    logic [N_BTN-1:0] level_prev_q, level_prev_d;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] clr;
    logic [N_BTN-1:0] pend_q, pend_d;
    logic [N_BTN-1:0] drop_q, drop_d;
    logic             state_q, state_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic             accept;
    logic             sel_found;
    logic [IDW-1:0]   sel_idx;

    always_comb begin
        tick         = (cnt_q == CNT_LAST);
        cnt_d        = tick ? '0 : cnt_q + CW'(1);
        sync1_d      = pb_in;
        sync2_d      = sync1_q;
        level_prev_d = level_q;
    end

    // One stable-sample filter per button, all advanced by the shared tick.
    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
            logic [STABLE_SAMPLES-1:0] hist_q, hist_d;
            logic                      lvl_d;

            always_comb begin
                hist_d = hist_q;
                lvl_d  = level_q[gi];
                if (tick) begin
                    hist_d = {hist_q[STABLE_SAMPLES-2:0], sync2_q[gi]};
                    if (&hist_d) begin
                        lvl_d = 1'b1;
                    end else if (~|hist_d) begin
                        lvl_d = 1'b0;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hist_q <= '0;
                end else begin
                    hist_q <= hist_d;
                end
            end

            assign level_d[gi] = lvl_d;
        end
    endgenerate

    // First pending request at or after ptr, wrapping modulo N_BTN.
    always_comb begin
        int j;
        sel_found = 1'b0;
        sel_idx   = '0;
        j         = 0;
        for (int k = 0; k < N_BTN; k++) begin
            j = int'(ptr_q) + k;
            if (j >= N_BTN) begin
                j = j - N_BTN;
            end
            if (!sel_found && pend_q[j]) begin
                sel_found = 1'b1;
                sel_idx   = IDW'(j);
            end
        end
    end

    always_comb begin
        accept = (state_q == ST_OFFER) && ev_ready;
        press  = level_q & ~level_prev_q;
        clr    = '0;
        for (int i = 0; i < N_BTN; i++) begin
            clr[i] = accept && (id_q == IDW'(i));
        end
        // A press coinciding with acceptance of the same id is a fresh request.
        pend_d  = press | (pend_q & ~clr);
        drop_d  = press & pend_q & ~clr;
        state_d = state_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    id_d    = sel_idx;
                    state_d = ST_OFFER;
                end
            end
            default: begin
                if (ev_ready) begin
                    state_d = ST_IDLE;
                    ptr_d   = (id_q == IDW'(N_BTN - 1)) ? '0 : id_q + IDW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            level_q      <= '0;
            level_prev_q <= '0;
            pend_q       <= '0;
            drop_q       <= '0;
            state_q      <= ST_IDLE;
            id_q         <= '0;
            ptr_q        <= '0;
        end else begin
            cnt_q        <= cnt_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
            pend_q       <= pend_d;
            drop_q       <= drop_d;
            state_q      <= state_d;
            id_q         <= id_d;
            ptr_q        <= ptr_d;
        end
    end

    assign ev_valid = (state_q == ST_OFFER);
    assign ev_id    = id_q;
    assign pb_level = level_q;
    assign ev_drop  = drop_q;

endmodule

// File: tb/tb_pb_event_arbiter.sv
// Scoreboard bench for pb_event_arbiter: expected ids are queued as buttons
// are pressed and compared when the DUT hands an event over.
module tb_pb_event_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] pb_in;
    logic       ev_ready;
    logic       ev_valid;
    logic [1:0] ev_id;
    logic [3:0] pb_level;
    logic [3:0] ev_drop;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int ev_cnt  = 0;
    int vrise_cyc = 0;
    int rise_cnt [4];
    int rise_cyc [4];
    int drop_cnt [4];
    int exp_q [$];
    int acc_cyc [$];

    logic       hold_prev  = 1'b0;
    logic       valid_prev = 1'b0;
    logic [1:0] id_prev    = '0;
    logic [3:0] lvl_prev   = '0;

    pb_event_arbiter #(
        .N_BTN         (4),
        .CLK_FREQ      (1000),
        .SAMPLE_HZ     (100),
        .STABLE_SAMPLES(3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pb_in   (pb_in),
        .ev_ready(ev_ready),
        .ev_valid(ev_valid),
        .ev_id   (ev_id),
        .pb_level(pb_level),
        .ev_drop (ev_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Monitor samples on the falling edge, half a cycle from any DUT update.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev  = 1'b0;
            valid_prev = 1'b0;
            lvl_prev   = pb_level;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", 32'(ev_valid), 32'(1));
                chk("hold_id", 32'(ev_id), 32'(id_prev));
            end
            if (ev_valid && !valid_prev) vrise_cyc = cyc;
            for (int i = 0; i < 4; i++) begin
                if (pb_level[i] && !lvl_prev[i]) begin
                    rise_cnt[i]++;
                    rise_cyc[i] = cyc;
                end
                if (ev_drop[i]) drop_cnt[i]++;
            end
            if (ev_valid && ev_ready) begin
                int e;
                ev_cnt++;
                acc_cyc.push_back(cyc);
                $display("event id=%0d cyc=%0d", ev_id, cyc);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("ev_id", 32'(ev_id), 32'(e));
                end
            end
            hold_prev  = ev_valid && !ev_ready;
            valid_prev = ev_valid;
            id_prev    = ev_id;
            lvl_prev   = pb_level;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_level(input string tag, input logic [3:0] mask, input logic [3:0] val,
                              input int limit, output int waited);
        waited = 0;
        while (((pb_level & mask) != val) && waited < limit) begin
            @(negedge clk);
            waited++;
        end
        chk(tag, 32'(pb_level & mask), 32'(val));
    endtask

    task automatic wait_events(input string tag, input int target, input int limit);
        int n;
        n = 0;
        while (ev_cnt < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(ev_cnt), 32'(target));
    endtask

    task automatic wait_valid(input string tag, input int limit);
        int n;
        n = 0;
        while (!ev_valid && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(ev_valid), 32'(1));
    endtask

    task automatic press_and_serve(input int b);
        int w;
        int base;
        logic [3:0] m;
        m = 4'(1 << b);
        base = ev_cnt;
        exp_q.push_back(b);
        step(1);
        pb_in = pb_in | m;
        wait_level("ps_up", m, m, 40, w);
        wait_events("ps_ev", base + 1, 20);
        step(1);
        pb_in = pb_in & ~m;
        wait_level("ps_dn", m, 4'h0, 40, w);
        step(1);
    endtask

    initial begin
        int w;
        int base;
        int r1;
        int d1;
        int rb;

        for (int i = 0; i < 4; i++) begin
            rise_cnt[i] = 0;
            rise_cyc[i] = 0;
            drop_cnt[i] = 0;
        end

        // Reset with every button held.
        rst_n    = 1'b0;
        pb_in    = 4'hF;
        ev_ready = 1'b0;
        step(5);
        chk("rst_valid", 32'(ev_valid), 32'(0));
        chk("rst_id", 32'(ev_id), 32'(0));
        chk("rst_level", 32'(pb_level), 32'(0));
        chk("rst_drop", 32'(ev_drop), 32'(0));
        for (int b = 0; b < 4; b++) exp_q.push_back(b);
        base = ev_cnt;
        rst_n = 1'b1;
        wait_level("rst_lvl_up", 4'hF, 4'hF, 40, w);
        chk("rst_lvl_time", 32'(w <= 33), 32'(1));
        step(1);
        ev_ready = 1'b1;
        wait_events("rst_ev4", base + 4, 40);
        pb_in = 4'h0;
        wait_level("rst_lvl_dn", 4'hF, 4'h0, 40, w);
        step(10);
        chk("rst_ev_total", 32'(ev_cnt - base), 32'(4));

        // Clean press of button 2.
        base = ev_cnt;
        exp_q.push_back(2);
        pb_in[2] = 1'b1;
        wait_level("clean_up", 4'h4, 4'h4, 40, w);
        chk("clean_time", 32'(w <= 33), 32'(1));
        wait_events("clean_ev", base + 1, 20);
        chk("clean_lat", 32'(vrise_cyc - rise_cyc[2]), 32'(2));
        step(1);
        pb_in[2] = 1'b0;
        wait_level("clean_dn", 4'h4, 4'h0, 40, w);
        step(10);
        chk("clean_count", 32'(ev_cnt - base), 32'(1));

        // Bouncing button 1.
        base = ev_cnt;
        r1 = rise_cnt[1];
        exp_q.push_back(1);
        for (int k = 0; k < 12; k++) begin
            pb_in[1] = ((k % 2) == 0);
            step(5);
        end
        pb_in[1] = 1'b1;
        step(50);
        chk("bounce_count", 32'(ev_cnt - base), 32'(1));
        chk("bounce_rises", 32'(rise_cnt[1] - r1), 32'(1));
        pb_in[1] = 1'b0;
        wait_level("bounce_dn", 4'h2, 4'h0, 40, w);
        step(10);
        chk("bounce_no_rel", 32'(ev_cnt - base), 32'(1));

        // Round robin: serve 3 so the pointer wraps to 0, then press 0,1,3.
        press_and_serve(3);
        base = ev_cnt;
        rb = acc_cyc.size();
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(3);
        pb_in = 4'b1011;
        wait_events("rr1_ev", base + 3, 60);
        chk("rr1_n_acc", 32'(acc_cyc.size() - rb), 32'(3));
        if (acc_cyc.size() - rb >= 3) begin
            chk("rr1_gap0", 32'(acc_cyc[rb+1] - acc_cyc[rb]), 32'(2));
            chk("rr1_gap1", 32'(acc_cyc[rb+2] - acc_cyc[rb+1]), 32'(2));
        end
        step(1);
        pb_in = 4'h0;
        wait_level("rr1_dn", 4'hF, 4'h0, 40, w);
        step(2);
        // Serving 1 leaves the pointer at 2, so 3 must win over 0.
        press_and_serve(1);
        base = ev_cnt;
        exp_q.push_back(3);
        exp_q.push_back(0);
        pb_in = 4'b1001;
        wait_events("rr2_ev", base + 2, 60);
        step(1);
        pb_in = 4'h0;
        wait_level("rr2_dn", 4'hF, 4'h0, 40, w);
        step(2);

        // Backpressure and drop on button 1.
        base = ev_cnt;
        d1 = drop_cnt[1];
        ev_ready = 1'b0;
        exp_q.push_back(1);
        pb_in[1] = 1'b1;
        wait_level("bp_up1", 4'h2, 4'h2, 40, w);
        wait_valid("bp_valid", 10);
        step(5);
        pb_in[1] = 1'b0;
        wait_level("bp_dn", 4'h2, 4'h0, 40, w);
        step(1);
        pb_in[1] = 1'b1;
        wait_level("bp_up2", 4'h2, 4'h2, 40, w);
        step(4);
        chk("bp_drop", 32'(drop_cnt[1] - d1), 32'(1));
        chk("bp_still_valid", 32'(ev_valid), 32'(1));
        chk("bp_still_id", 32'(ev_id), 32'(1));
        chk("bp_no_acc", 32'(ev_cnt - base), 32'(0));
        ev_ready = 1'b1;
        step(10);
        chk("bp_one_acc", 32'(ev_cnt - base), 32'(1));
        pb_in[1] = 1'b0;
        wait_level("bp_dn2", 4'h2, 4'h0, 40, w);
        step(2);

        // Asynchronous reset while an event is being offered.
        base = ev_cnt;
        ev_ready = 1'b0;
        pb_in[0] = 1'b1;
        wait_valid("mr_valid", 50);
        step(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_valid0", 32'(ev_valid), 32'(0));
        chk("mr_id0", 32'(ev_id), 32'(0));
        chk("mr_level0", 32'(pb_level), 32'(0));
        pb_in = 4'h0;
        step(3);
        rst_n = 1'b1;
        ev_ready = 1'b1;
        step(50);
        chk("mr_no_stale", 32'(ev_cnt - base), 32'(0));
        chk("mr_idle", 32'(ev_valid), 32'(0));

        chk("sb_empty", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
